// File: rtl/reor_pkg.sv
// reor_pkg: shared encodings for the sequential reduction controller.
//   op_t    - 2-input operation applied along the reduction chain.
//   state_t - controller state (IDLE / STEP / DONE).
//   is_determining - true when acc already fixes the final result.
package reor_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  // OR/NOR saturate at 1, AND saturates at 0, XOR never saturates.
  function automatic logic is_determining(input op_t op, input logic acc);
    logic det;
    det = 1'b0;
    case (op)
      OP_OR, OP_NOR: det = acc;
      OP_AND:        det = ~acc;
      default:       det = 1'b0;
    endcase
    return det;
  endfunction

endpackage

// File: rtl/reor_step_gate.sv
// reor_step_gate: the single shared 2-input gate the controller sequences.
//   a, b : gate inputs (a = current operand bit, b = accumulator)
//   op   : operation select
//   y    : gate output
// NOR evaluates as OR; the inversion is applied once on the final result.
module reor_step_gate
  import reor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  op_t  op,
  output logic y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = a | b;
    endcase
  end

endmodule

// File: rtl/reor_seq_ctrl.sv
// reor_seq_ctrl: reduces a WIDTH-bit vector one bit per clock through a
// single shared gate: acc = din[0]; acc = din[i] op acc for i = 1..WIDTH-1.
//   clk, rst      : clock, asynchronous active-high reset
//   start, op, din: request; sampled only while ready
//   ready / busy / done : IDLE / STEP / DONE (done is a one-cycle pulse)
//   result, steps : reduction result and gate evaluations used; both
//                   update only on entry to DONE and hold otherwise
// Handshake: a request is taken on a rising edge where start && ready;
// start at any other time is dropped, never queued.
module reor_seq_ctrl
  import reor_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic [CW-1:0]    steps
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] din_q;
  op_t              op_q;
  logic             acc;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    cnt;

  logic          load, step_en, fin;
  logic          bit_sel, gate_y;
  logic          final_acc;
  logic [CW-1:0] final_cnt;
  op_t           final_op;

  // Mux the current operand bit out of the shadow register; a compare
  // loop keeps the index width independent of the vector width.
  always_comb begin
    bit_sel = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == CW'(i)) bit_sel = din_q[i];
    end
  end

  reor_step_gate u_gate (
    .a  (bit_sel),
    .b  (acc),
    .op (op_q),
    .y  (gate_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = (WIDTH == 1) ? DONE : STEP;
        end
      end
      STEP: begin
        step_en = 1'b1;
        if (idx == LAST_IDX ||
            (EARLY_EXIT != 0 && is_determining(op_q, gate_y)))
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Values that land in result/steps on the edge that enters DONE. From
  // IDLE (WIDTH==1) nothing was evaluated; from STEP the step just taken
  // counts.
  assign fin       = (state_n == DONE) && (state != DONE);
  assign final_acc = (state == IDLE) ? din[0] : gate_y;
  assign final_cnt = (state == IDLE) ? '0 : cnt + CW'(1);
  assign final_op  = (state == IDLE) ? op_t'(op) : op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q  <= '0;
      op_q   <= OP_OR;
      acc    <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      result <= 1'b0;
      steps  <= '0;
    end else begin
      if (load) begin
        din_q <= din;
        op_q  <= op_t'(op);
        acc   <= din[0];
        idx   <= CW'(1);
        cnt   <= '0;
      end else if (step_en) begin
        acc <= gate_y;
        idx <= idx + CW'(1);
        cnt <= cnt + CW'(1);
      end
      if (fin) begin
        result <= (final_op == OP_NOR) ? ~final_acc : final_acc;
        steps  <= final_cnt;
      end
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == STEP);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_reor_seq_ctrl.sv
// Bench for reor_seq_ctrl: three instances (WIDTH=8 with early exit,
// WIDTH=8 without, WIDTH=1). Drivers push {done_edge, steps, result} into
// a per-instance queue; one monitor pops on every done pulse.
module tb_reor_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic       start_a = 0, start_b = 0, start_c = 0;
  logic [1:0] op_a = 0, op_b = 0, op_c = 0;
  logic [7:0] din_a = 0, din_b = 0;
  logic [0:0] din_c = 0;
  logic       ready_a, busy_a, done_a, result_a;
  logic       ready_b, busy_b, done_b, result_b;
  logic       ready_c, busy_c, done_c, result_c;
  logic [3:0] steps_a, steps_b;
  logic [0:0] steps_c;

  reor_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .op(op_a), .din(din_a),
    .ready(ready_a), .busy(busy_a), .done(done_a), .result(result_a), .steps(steps_a));

  reor_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .op(op_b), .din(din_b),
    .ready(ready_b), .busy(busy_b), .done(done_b), .result(result_b), .steps(steps_b));

  reor_seq_ctrl #(.WIDTH(1), .EARLY_EXIT(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .op(op_c), .din(din_c),
    .ready(ready_c), .busy(busy_c), .done(done_c), .result(result_c), .steps(steps_c));

  // ---------------- scoreboard ----------------
  localparam int EW = 41;  // {done_edge[31:0], steps[7:0], result}
  logic [EW-1:0] exp_a[$];
  logic [EW-1:0] exp_b[$];
  logic [EW-1:0] exp_c[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int sel, input int unsigned done_edge,
                      input int exp_steps, input logic exp_res);
    logic [EW-1:0] e;
    e = {done_edge[31:0], exp_steps[7:0], exp_res};
    case (sel)
      0:       exp_a.push_back(e);
      1:       exp_b.push_back(e);
      default: exp_c.push_back(e);
    endcase
  endtask

  function automatic logic ready_of(input int sel);
    case (sel)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  task automatic mon(input int sel, input string nm, input logic rd, input logic bs,
                     input logic dn, input logic res, input logic [7:0] st);
    logic [EW-1:0] e;
    bit have;
    check({nm, " onehot"}, 32'($onehot({rd, bs, dn})), 32'd1);
    if (dn) begin
      have = 0;
      e    = '0;
      case (sel)
        0: if (exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1; end
        1: if (exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1; end
        default: if (exp_c.size() > 0) begin e = exp_c.pop_front(); have = 1; end
      endcase
      if (!have) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s unexpected done: got done=1 expected no done (edge %0d)", nm, cyc);
      end else begin
        check({nm, " result"}, 32'(res), 32'(e[0]));
        check({nm, " steps"}, 32'(st), 32'(e[8:1]));
        check({nm, " done_edge"}, cyc, e[40:9]);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, "a", ready_a, busy_a, done_a, result_a, {4'd0, steps_a});
    mon(1, "b", ready_b, busy_b, done_b, result_b, {4'd0, steps_b});
    mon(2, "c", ready_c, busy_c, done_c, result_c, {7'd0, steps_c});
  end

  // ---------------- drivers ----------------
  // Wait for ready, present one request for one edge, log the expectation.
  task automatic issue(input int sel, input logic [1:0] o, input logic [7:0] d,
                       input logic exp_res, input int exp_steps);
    bit ok;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ready_of(sel)) begin ok = 1; break; end
    end
    check("issue ready", 32'(ok), 32'd1);
    if (!ok) return;
    case (sel)
      0: begin start_a = 1; op_a = o; din_a = d; end
      1: begin start_b = 1; op_b = o; din_b = d; end
      default: begin start_c = 1; op_c = o; din_c = d[0]; end
    endcase
    push(sel, cyc + 1 + exp_steps, exp_steps, exp_res);
    @(negedge clk);
    start_a = 0; start_b = 0; start_c = 0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300; t++) begin
      if (exp_a.size() == 0 && exp_b.size() == 0 && exp_c.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  int unsigned k;

  initial begin
    // reset state
    @(negedge clk);
    check("rst ready", 32'(ready_a), 32'd1);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst result", 32'(result_a), 32'd0);
    check("rst steps", 32'(steps_a), 32'd0);
    check("rst steps c", 32'(steps_c), 32'd0);
    rst = 0;

    // full-length reductions without early exit
    issue(1, 2'd0, 8'h00, 1'b0, 7);
    issue(1, 2'd0, 8'h02, 1'b1, 7);
    issue(1, 2'd2, 8'h01, 1'b1, 7);

    // early exit instance
    issue(0, 2'd0, 8'h02, 1'b1, 1);
    issue(0, 2'd0, 8'h80, 1'b1, 7);
    issue(0, 2'd1, 8'hFF, 1'b1, 7);
    issue(0, 2'd2, 8'hA5, 1'b0, 7);
    issue(0, 2'd3, 8'h00, 1'b1, 7);
    issue(0, 2'd1, 8'hFE, 1'b0, 1);
    issue(0, 2'd1, 8'hF7, 1'b0, 3);
    issue(0, 2'd3, 8'h10, 1'b0, 4);

    // WIDTH == 1
    issue(2, 2'd3, 8'h01, 1'b0, 0);
    issue(2, 2'd0, 8'h01, 1'b1, 0);
    issue(2, 2'd3, 8'h00, 1'b1, 0);
    wait_drain();

    // start held high; din changes mid-STEP; second accept one cycle after done
    @(negedge clk);
    check("held ready", 32'(ready_a), 32'd1);
    start_a = 1; op_a = 2'd0; din_a = 8'h00;
    k = cyc + 1;
    push(0, k + 7, 7, 1'b0);
    push(0, k + 9 + 1, 1, 1'b1);
    repeat (3) @(negedge clk);
    din_a = 8'h01;
    while (cyc < k + 9) @(negedge clk);
    start_a = 0;
    wait_drain();

    // asynchronous reset in the middle of a reduction
    issue(1, 2'd1, 8'hFF, 1'b1, 7);
    wait_drain();
    @(negedge clk);
    start_b = 1; op_b = 2'd0; din_b = 8'h00;
    k = cyc + 1;
    @(negedge clk);
    start_b = 0;
    while (cyc < k + 3) @(negedge clk);
    check("mid busy", 32'(busy_b), 32'd1);
    check("mid result held", 32'(result_b), 32'd1);
    check("mid steps held", 32'(steps_b), 32'd7);
    #1 rst = 1;
    #1;
    check("async ready", 32'(ready_b), 32'd1);
    check("async busy", 32'(busy_b), 32'd0);
    check("async done", 32'(done_b), 32'd0);
    check("async result", 32'(result_b), 32'd0);
    check("async steps", 32'(steps_b), 32'd0);
    @(negedge clk);
    rst = 0;
    issue(1, 2'd0, 8'h01, 1'b1, 7);
    wait_drain();

    // anything still queued never completed
    while (exp_a.size() > 0) begin
      void'(exp_a.pop_front()); n_checks++; n_fail++;
      $display("FAIL a pending: got no done expected done");
    end
    while (exp_b.size() > 0) begin
      void'(exp_b.pop_front()); n_checks++; n_fail++;
      $display("FAIL b pending: got no done expected done");
    end
    while (exp_c.size() > 0) begin
      void'(exp_c.pop_front()); n_checks++; n_fail++;
      $display("FAIL c pending: got no done expected done");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
